box_overlay_stream: RTL and testbench

Video-stream consumer of the box coordinates produced by the button-driven box controller. It receives the live pixel stream as AXI4-Stream video with `tuser` as start of frame and `tlast` as end of line. It tracks each pixel's column and row, and replaces every pixel on the rectangle border with a fixed colour. It sits between the camera/VDMA read path and the HDMI output, so the user sees the region the k-means core will operate on.

---
 rtl/box_overlay_stream.sv | 184 ++++++++++++++++++
 tb/tb_box_overlay_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_overlay_stream.sv
// box_overlay_stream: draws a fixed-colour rectangle border onto an
// AXI4-Stream video feed (tuser = start of frame, tlast = end of line).
// A single output register provides 1-cycle latency at full throughput.
// Box corners are sampled at each start of frame so a mid-frame change
// never tears the box.
module box_overlay_stream #(
  parameter int                    IMAGE_WIDTH  = 1280,
  parameter int                    IMAGE_HEIGHT = 720,
  parameter int                    DATA_WIDTH   = 24,
  parameter int                    BORDER       = 2,
  parameter logic [DATA_WIDTH-1:0] BOX_COLOR    = 24'hFF0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           x1_i,
  input  logic [15:0]           x2_i,
  input  logic [15:0]           y1_i,
  input  logic [15:0]           y2_i,
  input  logic                  overlay_en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  box_valid,
  output logic [15:0]           frame_count,
  output logic                  line_err
);

  typedef logic [11:0] coord_t;
  typedef logic [12:0] wide_t;

  // Position counters and the shadow copy of the box taken at SOF.
  coord_t col_q, col_d, row_q, row_d;
  coord_t x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic   box_valid_q, box_valid_d;
  logic   [15:0] frame_count_q, frame_count_d;
  logic   line_err_q, line_err_d;

  // Output stage.
  logic                  m_valid_q, m_valid_d;
  logic                  m_user_q, m_user_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic   accept;
  logic   live_legal;
  coord_t cur_col, cur_row;
  coord_t eff_x1, eff_x2, eff_y1, eff_y2;
  logic   eff_valid;
  wide_t  c13, r13, x1_13, x2_13, y1_13, y2_13;
  wide_t  bd13;
  logic   in_box, near_edge, in_rows, is_border;

  // The output register can take a new beat whenever it is empty or draining.
  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Legality is judged on the full 16-bit inputs so out-of-range upper bits
  // are not hidden by the 12-bit truncation of the shadow copy.
  assign live_legal = (x1_i <= x2_i) && (y1_i <= y2_i) &&
                      (x2_i < 16'(IMAGE_WIDTH)) && (y2_i < 16'(IMAGE_HEIGHT));

  // The SOF pixel is (0,0) and is judged against the live corners, since the
  // shadow copy only becomes visible on the following cycle.
  assign cur_col   = s_axis_tuser ? '0 : col_q;
  assign cur_row   = s_axis_tuser ? '0 : row_q;
  assign eff_x1    = s_axis_tuser ? x1_i[11:0] : x1_q;
  assign eff_x2    = s_axis_tuser ? x2_i[11:0] : x2_q;
  assign eff_y1    = s_axis_tuser ? y1_i[11:0] : y1_q;
  assign eff_y2    = s_axis_tuser ? y2_i[11:0] : y2_q;
  assign eff_valid = s_axis_tuser ? live_legal : box_valid_q;

  // One extra bit keeps corner+BORDER from wrapping near 4095.
  assign c13   = {1'b0, cur_col};
  assign r13   = {1'b0, cur_row};
  assign x1_13 = {1'b0, eff_x1};
  assign x2_13 = {1'b0, eff_x2};
  assign y1_13 = {1'b0, eff_y1};
  assign y2_13 = {1'b0, eff_y2};
  assign bd13  = 13'(BORDER);

  assign in_box    = (c13 >= x1_13) && (c13 <= x2_13) &&
                     (r13 >= y1_13) && (r13 <= y2_13);
  // A box thinner than twice the border satisfies one of these everywhere,
  // so it comes out solid.
  assign near_edge = (c13 < x1_13 + bd13) || (c13 + bd13 > x2_13) ||
                     (r13 < y1_13 + bd13) || (r13 + bd13 > y2_13);
  assign in_rows   = r13 < 13'(IMAGE_HEIGHT);
  assign is_border = overlay_en && eff_valid && in_box && near_edge && in_rows;

  // Next-state logic for counters, SOF latch, error flag and output stage.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    col_d         = col_q;
    row_d         = row_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    box_valid_d   = box_valid_q;
    frame_count_d = frame_count_q;
    line_err_d    = line_err_q;
    m_valid_d     = m_valid_q;
    m_user_d      = m_user_q;
    m_last_d      = m_last_q;
    m_data_d      = m_data_q;

    if (accept) begin
      if (s_axis_tlast) begin
        col_d = '0;
        row_d = cur_row + 12'd1;
      end else begin
        col_d = (cur_col == 12'hFFF) ? cur_col : cur_col + 12'd1;
        row_d = cur_row;
        if (c13 == 13'(IMAGE_WIDTH - 1)) line_err_d = 1'b1;
      end

      if (s_axis_tuser) begin
        x1_d          = x1_i[11:0];
        x2_d          = x2_i[11:0];
        y1_d          = y1_i[11:0];
        y2_d          = y2_i[11:0];
        box_valid_d   = live_legal;
        frame_count_d = frame_count_q + 16'd1;
      end

      m_user_d = s_axis_tuser;
      m_last_d = s_axis_tlast;
      m_data_d = is_border ? BOX_COLOR : s_axis_tdata;
    end

    // A free output slot either loads the accepted beat or empties.
    if (s_axis_tready) m_valid_d = s_axis_tvalid;
  end

  // State registers; reset drops any pending beat and disables the overlay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      x1_q          <= '0;
      x2_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      box_valid_q   <= 1'b0;
      frame_count_q <= '0;
      line_err_q    <= 1'b0;
      m_valid_q     <= 1'b0;
      m_user_q      <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      col_q         <= col_d;
      row_q         <= row_d;
      x1_q          <= x1_d;
      x2_q          <= x2_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      box_valid_q   <= box_valid_d;
      frame_count_q <= frame_count_d;
      line_err_q    <= line_err_d;
      m_valid_q     <= m_valid_d;
      m_user_q      <= m_user_d;
      m_last_q      <= m_last_d;
      m_data_q      <= m_data_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;
  assign box_valid     = box_valid_q;
  assign frame_count   = frame_count_q;
  assign line_err      = line_err_q;

endmodule

// File: tb/tb_box_overlay_stream.sv
// Directed bench for box_overlay_stream on a 16x8 image with a 1-pixel border.
module tb_box_overlay_stream;

  localparam int W = 16;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x1_i = '0, x2_i = '0, y1_i = '0, y2_i = '0;
  logic        overlay_en = 1'b0;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        box_valid;
  logic [15:0] frame_count;
  logic        line_err;

  int checks = 0;
  int errors = 0;
  int stall_bad = 0;
  bit bp_en = 1'b0;
  logic [25:0] out_q[$];

  box_overlay_stream #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(24),
    .BORDER(1), .BOX_COLOR(24'hFF0000)
  ) dut (
    .clk(clk), .rst(rst),
    .x1_i(x1_i), .x2_i(x2_i), .y1_i(y1_i), .y2_i(y2_i),
    .overlay_en(overlay_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .box_valid(box_valid), .frame_count(frame_count), .line_err(line_err)
  );

  always #5 clk = ~clk;

  // Random downstream readiness while backpressure is enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) m_axis_tready = 1'($urandom_range(0, 1));
  end

  // Output monitor: records handshaked beats and checks hold-while-stalled.
  initial begin
    logic        stall_prev;
    logic [25:0] snap;
    stall_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst && stall_prev &&
          ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== snap || m_axis_tvalid !== 1'b1))
        stall_bad++;
      if (!rst && m_axis_tvalid && m_axis_tready)
        out_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      stall_prev = !rst && m_axis_tvalid && !m_axis_tready;
      snap = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int mode, input int c, input int r);
    if (mode == 0) return 24'h000010;
    return 24'h100000 + 24'(r * 256 + c);
  endfunction

  // Hand-derived border maps for the boxes used below.
  function automatic bit exp_border(input int box_id, input int c, input int r);
    case (box_id)
      1: return ((r == 1 || r == 4) && c >= 2 && c <= 5) ||
                ((r == 2 || r == 3) && (c == 2 || c == 5));
      2: return ((r == 1 || r == 4) && c <= 5) ||
                ((r == 2 || r == 3) && (c == 0 || c == 5));
      3: return (r == 0 || r == 7 || c == 0 || c == 15);
      default: return 1'b0;
    endcase
  endfunction

  // Drive one beat and return at #1 after the edge that accepts it.
  task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        $display("FAIL beat_timeout: observed=no accept expected=accept within 200 cycles");
        $fatal(1);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Send a full 16x8 frame; optionally move x1 to 0 at the start of chg_row.
  task automatic send_frame(input int mode, input bit sof, input int chg_row, input bit lat_chk);
    out_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == chg_row && c == 0) x1_i = 16'd0;
        send_beat(pix(mode, c, r), sof && r == 0 && c == 0, c == W - 1);
        if (lat_chk && r == 0 && c == 0) begin
          chk("lat_valid", 32'(m_axis_tvalid), 32'd1);
          chk("lat_user", 32'(m_axis_tuser), 32'd1);
          chk("lat_data", 32'(m_axis_tdata), 32'h000010);
        end
      end
    end
  endtask

  // Wait for the frame to drain, then compare every beat with the border map.
  task automatic check_frame(input string tag, input int box_id, input int mode,
                             input bit sof, input int exp_red);
    int bad;
    int red;
    logic [25:0] e;
    bad = 0;
    red = 0;
    for (int i = 0; i < 100 && out_q.size() < W * H; i++) @(negedge clk);
    chk({tag, "_beats"}, 32'(out_q.size()), 32'(W * H));
    for (int i = 0; i < out_q.size() && i < W * H; i++) begin
      e[25]   = sof && i == 0;
      e[24]   = (i % W) == W - 1;
      e[23:0] = exp_border(box_id, i % W, i / W) ? 24'hFF0000 : pix(mode, i % W, i / W);
      if (out_q[i] !== e) bad++;
      if (out_q[i][23:0] == 24'hFF0000) red++;
    end
    chk({tag, "_bad"}, 32'(bad), 32'd0);
    chk({tag, "_red"}, 32'(red), 32'(exp_red));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_data", 32'(m_axis_tdata), 32'd0);
    chk("rst_m_user", 32'(m_axis_tuser), 32'd0);
    chk("rst_m_last", 32'(m_axis_tlast), 32'd0);
    chk("rst_box_valid", 32'(box_valid), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_line_err", 32'(line_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_s_ready", 32'(s_axis_tready), 32'd1);

    // Basic box; x1 moves to 0 at row 3 but frame 1 keeps (2,1)-(5,4).
    x1_i = 2; x2_i = 5; y1_i = 1; y2_i = 4;
    overlay_en = 1'b1;
    send_frame(0, 1'b1, 3, 1'b1);
    check_frame("f1", 1, 0, 1'b1, 12);
    chk("f1_box_valid", 32'(box_valid), 32'd1);
    chk("f1_frame_count", 32'(frame_count), 32'd1);

    // Next frame picks up x1 = 0.
    send_frame(0, 1'b1, -1, 1'b0);
    check_frame("f2", 2, 0, 1'b1, 16);
    chk("f2_frame_count", 32'(frame_count), 32'd2);

    // x2 beyond the image width: pass-through.
    x1_i = 2; x2_i = 20;
    send_frame(0, 1'b1, -1, 1'b0);
    check_frame("ill_x2", 0, 0, 1'b1, 0);
    chk("ill_x2_box_valid", 32'(box_valid), 32'd0);

    // x1 > x2: pass-through.
    x1_i = 5; x2_i = 2;
    send_frame(0, 1'b1, -1, 1'b0);
    check_frame("ill_x1gt", 0, 0, 1'b1, 0);
    chk("ill_x1gt_box_valid", 32'(box_valid), 32'd0);

    // Full-image box right after an illegal frame: SOF pixel uses live corners.
    x1_i = 0; x2_i = 15; y1_i = 0; y2_i = 7;
    send_frame(0, 1'b1, -1, 1'b0);
    check_frame("full", 3, 0, 1'b1, 44);
    chk("full_box_valid", 32'(box_valid), 32'd1);

    // Backpressure with per-pixel data so loss or duplication shows up.
    x1_i = 2; x2_i = 5; y1_i = 1; y2_i = 4;
    stall_bad = 0;
    bp_en = 1'b1;
    send_frame(1, 1'b1, -1, 1'b0);
    check_frame("bp", 1, 1, 1'b1, 12);
    bp_en = 1'b0;
    m_axis_tready = 1'b1;
    chk("bp_stall_hold", 32'(stall_bad), 32'd0);

    // Overlay disabled: pass-through even with a legal box.
    overlay_en = 1'b0;
    send_frame(1, 1'b1, -1, 1'b0);
    check_frame("dis", 0, 1, 1'b1, 0);
    overlay_en = 1'b1;

    // Line overrun: 17 beats on one line with no tlast.
    out_q.delete();
    for (int i = 0; i < 17; i++) begin
      send_beat(24'h000010, i == 0, 1'b0);
      if (i == 14) chk("ovr_before", 32'(line_err), 32'd0);
      if (i == 15) chk("ovr_set", 32'(line_err), 32'd1);
    end
    chk("ovr_sticky", 32'(line_err), 32'd1);

    // Stall a pending beat, then reset mid-frame.
    m_axis_tready = 1'b0;
    @(posedge clk);
    #1;
    chk("pend_valid", 32'(m_axis_tvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_m_valid", 32'(m_axis_tvalid), 32'd0);
    chk("mrst_m_data", 32'(m_axis_tdata), 32'd0);
    chk("mrst_line_err", 32'(line_err), 32'd0);
    chk("mrst_box_valid", 32'(box_valid), 32'd0);
    chk("mrst_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;

    // No SOF yet: nothing recoloured even though the live box is legal.
    send_frame(0, 1'b0, -1, 1'b0);
    check_frame("nosof", 0, 0, 1'b0, 0);
    chk("nosof_box_valid", 32'(box_valid), 32'd0);

    // Next SOF restores the overlay.
    send_frame(0, 1'b1, -1, 1'b0);
    check_frame("resume", 1, 0, 1'b1, 12);
    chk("resume_frame_count", 32'(frame_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
